// File: rtl/axi_dma_r_arbiter.sv
// Round-robin arbiter sharing one AXI burst-read DMA engine among N_REQ requesters.
// The grant is held for a whole BURST_LEN-beat burst, then priority rotates past the owner.
`ifndef DDR_ADDR_W
`define DDR_ADDR_W 32
`endif
`ifndef MIG_BUS_W
`define MIG_BUS_W 64
`endif

module axi_dma_r_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = `DDR_ADDR_W,
    parameter int DATA_W    = `MIG_BUS_W,
    parameter int BURST_LEN = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        req_last,
    output logic [DATA_W-1:0]       req_rdata,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    dma_valid,
    output logic [ADDR_W-1:0]       dma_addr,
    input  logic                    dma_ready,
    input  logic [DATA_W-1:0]       dma_rdata
);
    localparam int SW = $clog2(N_REQ);
    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [SW-1:0]     prio_ptr, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     beat_cnt, cnt_d;

    logic              pick_found;
    logic [SW-1:0]     pick_idx;
    int                scan_idx;
    logic              at_last;

    // First asserted request scanning upward from the slot after the last owner.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_idx = int'(prio_ptr) + k;
            if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
            if (!pick_found && req_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = SW'(scan_idx);
            end
        end
    end

    assign at_last = (beat_cnt == CW'(BURST_LEN - 1));

    always_comb begin
        state_d = state;
        grant_d = grant_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        cnt_d   = beat_cnt;
        ptr_d   = prio_ptr;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    sel_d   = pick_idx;
                    addr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (dma_ready) begin
                    cnt_d = beat_cnt + 1'b1;
                    if (at_last) begin
                        state_d = IDLE;
                        grant_d = '0;
                        ptr_d   = sel_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant_q  <= '0;
            sel_q    <= '0;
            prio_ptr <= SW'(N_REQ - 1);
            addr_q   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_d;
            grant_q  <= grant_d;
            sel_q    <= sel_d;
            prio_ptr <= ptr_d;
            addr_q   <= addr_d;
            beat_cnt <= cnt_d;
        end
    end

    // Handshake outputs come from registered state only, so dma_valid drops right after the last beat.
    assign busy      = (state == BUSY);
    assign grant     = grant_q;
    assign dma_valid = busy;
    assign dma_addr  = busy ? addr_q : '0;
    assign req_ready = grant_q & {N_REQ{dma_ready & busy}};
    assign req_last  = req_ready & {N_REQ{at_last}};
    assign req_rdata = dma_rdata;

endmodule
